regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file: configurable data width, register count, read-port count and write-port count.
- Adds a per-register scoreboard (busy bits) for decode-stage hazard detection.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear) in the core pipeline.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of 2, at least 2.
- NUM_RD, 2, number of read ports; 1..4.
- NUM_WR, 1, number of write ports; 1..2.
- ADDR_W, $clog2(NUM_REGS), local/derived address width; not user-overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
- rd_busy  out  NUM_RD  scoreboard busy bit for each read address, combinational.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- sb_set_en  in  1  mark sb_set_addr busy (instruction issued with destination).
- sb_set_addr  in  ADDR_W  destination register being issued.
- sb_flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_count  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (reset_n low, asynchronous assert): all registers = 0, all busy bits = 0, busy_count = 0. Deassertion takes effect at the next rising edge. rd_data reads 0 and rd_busy = 0 for every address while reset is held and on the first cycle after.
- Reset mid-operation: pending writes and sets are discarded. No partial update is allowed.
- Read: rd_data[i] = registers[rd_addr[i]]. Zero latency. Address 0 always returns 0.
- Write: on the rising edge with wr_en[j] = 1 and wr_addr[j] != 0, registers[wr_addr[j]] <= wr_data[j]. Writes to address 0 are ignored.
- Write-write conflict (both ports, same non-zero address, same cycle): the higher port index wins.
- Scoreboard clear: any accepted write (wr_en[j], addr != 0) clears busy[wr_addr[j]] at that edge.
- Scoreboard set: sb_set_en with sb_set_addr != 0 sets busy[sb_set_addr]. Set on address 0 is ignored.
- Set and clear of the same register in the same cycle: set wins; the new producer is outstanding.
- Re-set of an already busy register: stays busy, no error.
- sb_flush: all busy bits = 0 at that edge. Flush has priority over a same-cycle set. Same-cycle register writes still complete.
- rd_busy[i] = busy[rd_addr[i]], combinational, reflecting state before the current edge.
- busy_count: registered population count of busy bits after the edge's update. Range 0..NUM_REGS-1.
- Timing: no combinational path from wr_* to rd_* except under the optional feature.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If any wr_en[j] with wr_addr[j] == rd_addr[i] != 0, rd_data[i] returns that wr_data[j] in the same cycle; the highest matching j wins.
  - Under the same match, rd_busy[i] reads 0, unless sb_set_en targets the same address that cycle, in which case rd_busy[i] reads 1.
- Undefined: reads return the pre-edge register value; written data is visible the cycle after the write; rd_busy ignores same-cycle writes.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rd_data = 0, rd_busy = 0, busy_count = 0.
- Write 0xDEADBEEF to x5; next cycle read x5 and x0 -> rd_data = 0xDEADBEEF and 0. Then write 0x1234 to x0 -> x0 still reads 0.
- NUM_WR = 2: both ports write x7 in the same cycle, port0 = 0x11, port1 = 0x22 -> x7 reads 0x22.
- Set x3 busy -> rd_busy = 1 next cycle and busy_count = 1. Same cycle: write x3 plus set x3 -> still busy. Write x3 alone -> busy = 0, busy_count = 0.
- Set x1, x2, x4 busy -> busy_count = 3. Assert sb_flush with a set of x6 in the same cycle -> all busy = 0, busy_count = 0.
- REGFILE_BYPASS_EN: in one cycle write x9 = 0xCAFE while reading x9 -> rd_data = 0xCAFE that cycle. Without the macro, the same stimulus returns the old value, then 0xCAFE next cycle.
- Assert reset_n low mid-cycle during a write of x10 -> x10 reads 0 and all busy bits clear immediately.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard; x0 is hardwired to zero and never busy.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     sb_flush,
  output logic [ADDR_W:0]          busy_count
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     busy_count_q;
  logic [ADDR_W:0]     busy_count_d;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] n;
    n = {(ADDR_W+1){1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      n = n + {{ADDR_W{1'b0}}, v[k]};
    end
    return n;
  endfunction

  // Next state: writes in ascending port order so the highest port wins; set beats clear, flush beats set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
        regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
        busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end else begin
        regs_d[0] = {DATA_W{1'b0}};
      end
    end
    if (sb_flush) begin
      busy_d = {NUM_REGS{1'b0}};
    end else if (sb_set_en && (sb_set_addr != ZERO_ADDR)) begin
      busy_d[sb_set_addr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    regs_d[0]    = {DATA_W{1'b0}};
    busy_d[0]    = 1'b0;
    busy_count_d = popcount(busy_d);
  end

  // State registers; an asserted reset discards any same-cycle update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= {DATA_W{1'b0}};
      end
      busy_q       <= {NUM_REGS{1'b0}};
      busy_count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  // Read ports; x0 reads zero because its storage and busy bit are held at zero.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
      rd_busy[i]                  = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        rd_data[i*DATA_W +: DATA_W] =
          (reset_n && wr_en[j] && (rd_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR) &&
           (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]))
          ? wr_data[j*DATA_W +: DATA_W] : rd_data[i*DATA_W +: DATA_W];
        rd_busy[i] =
          (reset_n && wr_en[j] && (rd_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR) &&
           (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]))
          ? (sb_set_en && (sb_set_addr == rd_addr[i*ADDR_W +: ADDR_W])) : rd_busy[i];
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (two write ports): directed scenarios plus randomized
// stimulus compared against an array-based reference model. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        sb_flush;
  logic [5:0]  busy_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_mp_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set_en(sb_set_en),
    .sb_set_addr(sb_set_addr), .sb_flush(sb_flush), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_busy[r] = 1'b0;
    end
  endfunction

  // Architectural effect of one rising edge given the inputs currently applied.
  function automatic void model_edge();
    logic [4:0] wa;
    if (!reset_n) return;
    for (int j = 0; j < 2; j++) begin
      wa = wr_addr[j*5 +: 5];
      if (wr_en[j] && wa != 5'd0) begin
        m_regs[wa] = wr_data[j*32 +: 32];
        m_busy[wa] = 1'b0;
      end
    end
    if (sb_flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end else if (sb_set_en && sb_set_addr != 5'd0) begin
      m_busy[sb_set_addr] = 1'b1;
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(int i);
    logic [4:0]  a;
    logic [31:0] r;
    a = rd_addr[i*5 +: 5];
    if (a == 5'd0 || !reset_n) return 32'd0;
    r = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*5 +: 5] == a) r = wr_data[j*32 +: 32];
`endif
    return r;
  endfunction

  function automatic logic exp_busy(int i);
    logic [4:0] a;
    logic       b;
    a = rd_addr[i*5 +: 5];
    if (a == 5'd0 || !reset_n) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*5 +: 5] == a) b = sb_set_en && (sb_set_addr == a);
`endif
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = 10'd0; wr_data = 64'd0;
    sb_set_en = 1'b0; sb_set_addr = 5'd0; sb_flush = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      checks++;
      if (rd_data !== 64'd0) begin
        errors++; $display("FAIL reset_rd_data addr=%0d: got %h expected 0", a, rd_data);
      end
      checks++;
      if (rd_busy !== 2'b00) begin
        errors++; $display("FAIL reset_rd_busy addr=%0d: got %b expected 00", a, rd_busy);
      end
    end
    checks++;
    if (busy_count !== 6'd0) begin
      errors++; $display("FAIL reset_busy_count: got %0d expected 0", busy_count);
    end
    reset_n = 1'b1;
    tick();
    set_rd(5'd5, 5'd31);
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL reset_first_cycle: got data=%h busy=%b expected 0", rd_data, rd_busy);
    end
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    tick(); idle();
    set_rd(5'd5, 5'd0);
    #1;
    checks++;
    if (rd_data !== {32'd0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL write_x5_read: got %h expected %h", rd_data, {32'd0, 32'hDEADBEEF});
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h00001234};
    tick(); idle();
    set_rd(5'd0, 5'd5);
    #1;
    checks++;
    if (rd_data !== {32'hDEADBEEF, 32'd0}) begin
      errors++; $display("FAIL write_x0_ignored: got %h expected %h", rd_data, {32'hDEADBEEF, 32'd0});
    end
  endtask

  task automatic test_write_conflict();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    tick(); idle();
    set_rd(5'd7, 5'd7);
    #1;
    checks++;
    if (rd_data !== {32'h22, 32'h22}) begin
      errors++; $display("FAIL write_conflict_x7: got %h expected %h", rd_data, {32'h22, 32'h22});
    end
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick(); idle();
    set_rd(5'd3, 5'd0);
    #1;
    checks++;
    if (rd_busy !== 2'b01 || busy_count !== 6'd1) begin
      errors++; $display("FAIL sb_set_x3: got busy=%b count=%0d expected 01 1", rd_busy, busy_count);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h33};
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick(); idle();
    #1;
    checks++;
    if (rd_busy !== 2'b01 || busy_count !== 6'd1) begin
      errors++; $display("FAIL sb_set_beats_clear: got busy=%b count=%0d expected 01 1", rd_busy, busy_count);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h44};
    tick(); idle();
    #1;
    checks++;
    if (rd_busy !== 2'b00 || busy_count !== 6'd0 || rd_data[31:0] !== 32'h44) begin
      errors++; $display("FAIL sb_write_clears: got busy=%b count=%0d data=%h expected 00 0 44",
                         rd_busy, busy_count, rd_data[31:0]);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      sb_set_en = 1'b1; sb_set_addr = (k == 2) ? 5'd4 : 5'(k + 1);
      tick();
    end
    idle();
    #1;
    checks++;
    if (busy_count !== 6'd3) begin
      errors++; $display("FAIL flush_pre_count: got %0d expected 3", busy_count);
    end
    sb_flush = 1'b1; sb_set_en = 1'b1; sb_set_addr = 5'd6;
    tick(); idle();
    set_rd(5'd6, 5'd2);
    #1;
    checks++;
    if (busy_count !== 6'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL flush_beats_set: got count=%0d busy=%b expected 0 00", busy_count, rd_busy);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] same_cycle;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h00000BAD};
    tick(); idle();
`ifdef REGFILE_BYPASS_EN
    same_cycle = 32'h0000CAFE;
`else
    same_cycle = 32'h00000BAD;
`endif
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h0000CAFE};
    set_rd(5'd9, 5'd9);
    #1;
    checks++;
    if (rd_data !== {same_cycle, same_cycle}) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data, {same_cycle, same_cycle});
    end
    tick(); idle();
    #1;
    checks++;
    if (rd_data !== {32'h0000CAFE, 32'h0000CAFE}) begin
      errors++; $display("FAIL bypass_next_cycle: got %h expected %h", rd_data, {32'h0000CAFE, 32'h0000CAFE});
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h55};
    sb_set_en = 1'b1; sb_set_addr = 5'd11;
    tick(); idle();
    set_rd(5'd10, 5'd11);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h55 || rd_busy !== 2'b10) begin
      errors++; $display("FAIL reset_mid_setup: got data=%h busy=%b expected 55 10", rd_data[31:0], rd_busy);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h77};
    sb_set_en = 1'b1; sb_set_addr = 5'd12;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || busy_count !== 6'd0) begin
      errors++; $display("FAIL reset_mid_immediate: got data=%h busy=%b count=%0d expected 0",
                         rd_data, rd_busy, busy_count);
    end
    tick();
    checks++;
    if (rd_data !== 64'd0 || busy_count !== 6'd0) begin
      errors++; $display("FAIL reset_mid_held: got data=%h count=%0d expected 0", rd_data, busy_count);
    end
    idle();
    reset_n = 1'b1;
    tick();
    set_rd(5'd10, 5'd12);
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL reset_mid_after: got data=%h busy=%b expected 0", rd_data, rd_busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic        eb;
    for (int it = 0; it < 250; it++) begin
      wr_en = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wr_addr[j*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_data[j*32 +: 32] = $urandom;
      end
      sb_set_en   = 1'($urandom_range(0, 1));
      sb_set_addr = 5'($urandom_range(0, 7));
      sb_flush    = ($urandom_range(0, 15) == 0);
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      for (int i = 0; i < 2; i++) begin
        e  = exp_rd(i);
        eb = exp_busy(i);
        checks++;
        if (rd_data[i*32 +: 32] !== e) begin
          errors++; $display("FAIL rand_rd_data it=%0d port=%0d: got %h expected %h", it, i, rd_data[i*32 +: 32], e);
        end
        checks++;
        if (rd_busy[i] !== eb) begin
          errors++; $display("FAIL rand_rd_busy it=%0d port=%0d: got %b expected %b", it, i, rd_busy[i], eb);
        end
      end
      tick();
      checks++;
      if (int'(busy_count) != model_count()) begin
        errors++; $display("FAIL rand_busy_count it=%0d: got %0d expected %0d", it, busy_count, model_count());
      end
    end
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_write_conflict();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
